// File: rtl/float_pkg.sv
// Shared definitions for the sequential float accumulator.
// Holds the 2-bit FSM state encoding, single-precision constants and a
// leading-zero counter used by the adder during normalisation.
package float_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } fsm_state_t;

    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam int          FP_SIGN_BIT = 31;

    // Number of leading zeros in a 27-bit value; returns 27 for all-zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/floating.sv
// Single-cycle single-precision adder with a registered result.
// result is valid one clock edge after a/b/negate are presented.
// Round-to-nearest-even; exponent-0 operands are treated as zero and
// overflow saturates to infinity. No NaN/Inf input handling.
// Ports:
//   clk    - clock
//   a, b   - IEEE-754 single-precision operands
//   negate - when 1 the result is a - b instead of a + b
//   result - registered sum
//   debug  - internal alignment/normalisation status (observation only)
module floating
    import float_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        negate,
    output logic [31:0] result,
    output logic [7:0]  debug
);

    logic [31:0] w_b_eff;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic        w_swap;
    logic        w_eff_sub;
    logic [7:0]  w_exp_big;
    logic [7:0]  w_exp_small;
    logic [7:0]  w_exp_diff;
    logic [23:0] w_man_big;
    logic [23:0] w_man_small;
    logic [49:0] w_align;
    logic        w_sticky;
    logic [26:0] w_big_ext;
    logic [26:0] w_small_ext;
    logic [27:0] w_raw;
    logic [4:0]  w_lz;
    logic [26:0] w_norm;
    logic [9:0]  w_exp;
    logic        w_round_up;
    logic [24:0] w_man_rnd;
    logic [22:0] w_frac;
    logic [31:0] w_result;

    assign w_b_eff = {b[31] ^ negate, b[30:0]};

    // Order operands by magnitude so the subtraction below never goes negative.
    assign w_swap  = w_b_eff[30:0] > a[30:0];
    assign w_big   = w_swap ? w_b_eff : a;
    assign w_small = w_swap ? a : w_b_eff;

    assign w_eff_sub   = w_big[31] ^ w_small[31];
    assign w_exp_big   = w_big[30:23];
    assign w_exp_small = w_small[30:23];
    assign w_man_big   = {|w_exp_big, w_big[22:0]};
    assign w_man_small = {|w_exp_small, w_small[22:0]};
    assign w_exp_diff  = w_exp_big - w_exp_small;

    // Align the smaller mantissa, keeping guard, round and a sticky bit.
    // Past 25 positions the whole mantissa lands below the round bit.
    assign w_align     = {w_man_small, 26'd0} >> w_exp_diff;
    assign w_sticky    = (w_exp_diff > 8'd25) ? (|w_man_small) : (|w_align[23:0]);
    assign w_big_ext   = {w_man_big, 3'b000};
    assign w_small_ext = {w_align[49:24], w_sticky};

    assign w_raw = w_eff_sub ? ({1'b0, w_big_ext} - {1'b0, w_small_ext})
                             : ({1'b0, w_big_ext} + {1'b0, w_small_ext});
    assign w_lz  = lzc27(w_raw[26:0]);

    always_comb begin
        w_norm = w_raw[26:0] << w_lz;
        w_exp  = {2'b00, w_exp_big} - {5'd0, w_lz};
        if (w_raw[27]) begin
            // Carry out of the add: shift right once, folding the lost bit into sticky.
            w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_exp  = {2'b00, w_exp_big} + 10'd1;
        end
        w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_man_rnd  = {1'b0, w_norm[26:3]} + {24'd0, w_round_up};
        w_frac     = w_man_rnd[22:0];
        if (w_man_rnd[24]) begin
            w_frac = w_man_rnd[23:1];
            w_exp  = w_exp + 10'd1;
        end
        if (w_raw == 28'd0 || w_exp_big == 8'd0) begin
            w_result = FP_ZERO;
        end else if (w_exp[9] || w_exp == 10'd0) begin
            w_result = {w_big[31], 31'd0};
        end else if (w_exp >= 10'd255) begin
            w_result = {w_big[31], 8'hFF, 23'd0};
        end else begin
            w_result = {w_big[31], w_exp[7:0], w_frac};
        end
    end

    assign debug = {w_eff_sub, w_swap, w_sticky, w_lz};

    always_ff @(posedge clk) begin
        result <= w_result;
    end

endmodule

// File: rtl/float_sum_seq.sv
// Sequential single-precision accumulator.
// Elements arrive on a valid/ready stream and are added (or subtracted when
// in_sub=1) into a running sum; in_last closes the sum, which is then offered
// on a second valid/ready stream together with its element count.
// The first element of a sum is loaded directly; later elements go through
// the registered adder (ACCEPT -> ISSUE -> CAPTURE), one per three cycles.
// Ports:
//   clk, reset_n                     - clock, synchronous active-low reset
//   in_valid/in_ready                - element handshake
//   in_data, in_sub, in_last         - element value, subtract flag, end of sum
//   sum_valid/sum_ready              - completed-sum handshake
//   sum_data, sum_count              - completed sum and its element count
module float_sum_seq
    import float_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [31:0]      sum_data,
    output logic [CNT_W-1:0] sum_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    fsm_state_t       r_state;
    fsm_state_t       w_state_next;
    logic [31:0]      r_acc;
    logic [31:0]      w_acc_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [31:0]      r_op_a;
    logic [31:0]      w_op_a_next;
    logic [31:0]      r_op_b;
    logic [31:0]      w_op_b_next;
    logic             r_op_neg;
    logic             w_op_neg_next;
    logic             r_last_q;
    logic             w_last_q_next;
    logic [31:0]      w_adder_sum;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_accept;

    floating u_adder (
        .clk    (clk),
        .a      (r_op_a),
        .b      (r_op_b),
        .negate (r_op_neg),
        .result (w_adder_sum),
        .debug  ()
    );

    // Gating with reset_n keeps both handshakes quiet while reset is held.
    assign in_ready  = (r_state == ST_ACCEPT) && reset_n;
    assign sum_valid = (r_state == ST_DONE) && reset_n;
    assign sum_data  = r_acc;
    assign sum_count = r_count;

    assign w_accept    = in_valid && in_ready;
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : (r_count + CNT_ONE);

    always_comb begin
        w_state_next  = r_state;
        w_acc_next    = r_acc;
        w_count_next  = r_count;
        w_op_a_next   = r_op_a;
        w_op_b_next   = r_op_b;
        w_op_neg_next = r_op_neg;
        w_last_q_next = r_last_q;
        case (r_state)
            ST_ACCEPT: begin
                if (w_accept) begin
                    if (r_count == CNT_ZERO) begin
                        // First element bypasses the adder: a sign flip is all a subtract needs.
                        w_acc_next              = in_data;
                        w_acc_next[FP_SIGN_BIT] = in_data[FP_SIGN_BIT] ^ in_sub;
                        w_count_next            = CNT_ONE;
                        w_state_next            = in_last ? ST_DONE : ST_ACCEPT;
                    end else begin
                        w_op_a_next   = r_acc;
                        w_op_b_next   = in_data;
                        w_op_neg_next = in_sub;
                        w_last_q_next = in_last;
                        w_state_next  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Operands sit on the adder for this edge; its result register loads.
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_acc_next   = w_adder_sum;
                w_count_next = w_count_inc;
                w_state_next = r_last_q ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                if (sum_ready) begin
                    w_acc_next   = FP_ZERO;
                    w_count_next = CNT_ZERO;
                    w_state_next = ST_ACCEPT;
                end
            end
            default: begin
                w_state_next = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_ACCEPT;
            r_acc    <= FP_ZERO;
            r_count  <= CNT_ZERO;
            r_op_a   <= FP_ZERO;
            r_op_b   <= FP_ZERO;
            r_op_neg <= 1'b0;
            r_last_q <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_acc    <= w_acc_next;
            r_count  <= w_count_next;
            r_op_a   <= w_op_a_next;
            r_op_b   <= w_op_b_next;
            r_op_neg <= w_op_neg_next;
            r_last_q <= w_last_q_next;
        end
    end

endmodule

// File: tb/tb_float_sum_seq.sv
// Self-checking bench for float_sum_seq: reset, a table of directed sums,
// hand-written multi-cycle sequences, and randomized sums checked against a
// model that tracks each sum as an exact integer multiple of 1/8.
module tb_float_sum_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic        sum_ready;
    logic        in_ready;
    logic        sum_valid;
    logic [31:0] sum_data;
    logic [15:0] sum_count;
    logic        in_ready_s;
    logic        sum_valid_s;
    logic [31:0] sum_data_s;
    logic [1:0]  sum_count_s;

    int n_err    = 0;
    int n_checks = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    float_sum_seq #(.CNT_W(16)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_data  (sum_data),
        .sum_count (sum_count)
    );

    // Narrow-counter copy running in lockstep to exercise saturation.
    float_sum_seq #(.CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .sum_valid (sum_valid_s),
        .sum_ready (sum_ready),
        .sum_data  (sum_data_s),
        .sum_count (sum_count_s)
    );

    typedef struct {
        logic [31:0] d0;
        logic        s0;
        logic [31:0] d1;
        logic        s1;
        int          n;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: no handshake within cycle bound", name);
    endtask

    // Exact single-precision encoding of v/8 (|v| small enough to be exact).
    function automatic logic [31:0] fp8(input int v);
        int   m;
        int   p;
        logic s;
        if (v == 0) return 32'h00000000;
        s = (v < 0);
        m = s ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) begin
            if (((m >> i) & 1) == 1) p = i;
        end
        return {s, 8'(p + 124), 23'((m << (23 - p)) & 32'h007FFFFF)};
    endfunction

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [31:0] d, input logic s, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail_timeout("send");
        else @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom();
        in_sub   = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    // Waits for sum_valid (latency counted in cycles after the last accept),
    // holds off sum_ready for 'delay' cycles, checks, then completes the handshake.
    task automatic get_sum(input logic [31:0] exp_d, input int exp_n, input int exp_lat, input int delay);
        int lat;
        lat = 1;
        sum_ready = 1'b0;
        while (!sum_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!sum_valid) begin
            fail_timeout("sum_valid");
            return;
        end
        if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
        repeat (delay) @(negedge clk);
        check("sum_data", sum_data, exp_d);
        check("sum_count", {16'd0, sum_count}, 32'(exp_n));
        check("sat_count", {30'd0, sum_count_s}, 32'(sat3(exp_n)));
        check("sat_data", sum_data_s, exp_d);
        $display("txn %0d: sum_data=%h sum_count=%0d sat_count=%0d latency=%0d",
                 n_txn, sum_data, sum_count, sum_count_s, lat);
        n_txn++;
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check("valid_after_hs", {31'd0, sum_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          total;
        int          k;
        int          v;
        logic        sb;
        logic        seen;

        vecs[0]  = '{32'h3F800000, 1'b0, 32'h40000000, 1'b0, 2, 32'h40400000};
        vecs[1]  = '{32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1, 32'hBF800000};
        vecs[2]  = '{32'h40400000, 1'b0, 32'h3F800000, 1'b1, 2, 32'h40000000};
        vecs[3]  = '{32'h3F000000, 1'b0, 32'h3F000000, 1'b0, 2, 32'h3F800000};
        vecs[4]  = '{32'h40000000, 1'b0, 32'h40000000, 1'b1, 2, 32'h00000000};
        vecs[5]  = '{32'hC0A00000, 1'b0, 32'h40200000, 1'b0, 2, 32'hC0200000};
        vecs[6]  = '{32'h3FC00000, 1'b0, 32'h00000000, 1'b0, 1, 32'h3FC00000};
        vecs[7]  = '{32'h3F800000, 1'b0, 32'h33800000, 1'b0, 2, 32'h3F800000};
        vecs[8]  = '{32'h3F800000, 1'b0, 32'h34000000, 1'b0, 2, 32'h3F800001};
        vecs[9]  = '{32'h3F800001, 1'b0, 32'h33800000, 1'b0, 2, 32'h3F800002};
        vecs[10] = '{32'h3F800000, 1'b0, 32'h33800000, 1'b1, 2, 32'h3F7FFFFF};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        sum_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        check("rst_sum_count", {16'd0, sum_count}, 32'd0);
        check("rst_sum_data", sum_data, 32'h00000000);
        check("rst_sat_ready", {31'd0, in_ready_s}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].n == 1) begin
                send(vecs[i].d0, vecs[i].s0, 1'b1);
                get_sum(vecs[i].exp_d, 1, 1, 0);
            end else begin
                send(vecs[i].d0, vecs[i].s0, 1'b0);
                send(vecs[i].d1, vecs[i].s1, 1'b1);
                get_sum(vecs[i].exp_d, 2, 3, 0);
            end
        end

        // Backpressure: sum held, element stream stalled, offered element ignored
        send(32'h3F000000, 1'b0, 1'b0);
        send(32'h3F000000, 1'b0, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (sum_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) fail_timeout("bp_sum_valid");
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        for (int t = 0; t < 5; t++) begin
            check("bp_valid", {31'd0, sum_valid}, 32'd1);
            check("bp_data", sum_data, 32'h3F800000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check("bp_ready_after_hs", {31'd0, in_ready}, 32'd1);
        check("bp_count_cleared", {16'd0, sum_count}, 32'd0);
        check("bp_valid_after_hs", {31'd0, sum_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        send(32'h40800000, 1'b0, 1'b1);
        get_sum(32'h40800000, 1, 1, 0);

        // Reset during CAPTURE of a two-element sum
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h40000000, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, sum_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_count", {16'd0, sum_count}, 32'd0);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 4; t++) begin
            if (sum_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("mid_rst_no_pulse", {31'd0, seen}, 32'd0);
        send(32'h3FC00000, 1'b0, 1'b1);
        get_sum(32'h3FC00000, 1, 1, 0);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 5; i++) send(32'h3F800000, 1'b0, 1'(i == 4));
        get_sum(32'h40A00000, 5, 3, 0);

        // Randomized sums of exact eighths
        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(1, 8);
            total = 0;
            for (int i = 0; i < n; i++) begin
                k  = $urandom_range(1, 1000);
                v  = ($urandom_range(0, 1) == 1) ? -k : k;
                sb = 1'($urandom_range(0, 1));
                total += sb ? -v : v;
                send(fp8(v), sb, 1'(i == n - 1));
            end
            get_sum(fp8(total), n, (n == 1) ? 1 : 3, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/float_sum_seq.md
FLOAT_SUM_SEQ -- requirements
Module: float_sum_seq

Interface
REQ-001 Parameter CNT_W, default 16, is the width of the element counter.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port in_valid, input, 1 bit: in_data, in_sub and in_last are valid.
REQ-005 Port in_ready, output, 1 bit: the element is accepted on an edge where in_valid and in_ready are both 1.
REQ-006 Port in_data, input, 32 bits: IEEE-754 single-precision element.
REQ-007 Port in_sub, input, 1 bit: the element is subtracted from the running sum instead of added.
REQ-008 Port in_last, input, 1 bit: the element closes the current sum.
REQ-009 Port sum_valid, output, 1 bit: sum_data and sum_count hold a completed sum.
REQ-010 Port sum_ready, input, 1 bit: the completed sum is consumed on an edge where sum_valid and sum_ready are both 1.
REQ-011 Port sum_data, output, 32 bits: the completed single-precision sum.
REQ-012 Port sum_count, output, CNT_W bits: number of elements in the completed sum.

Function
REQ-013 The FSM SHALL have states ACCEPT, ISSUE, CAPTURE and DONE.
REQ-014 in_ready SHALL be 1 only in ACCEPT with reset_n high.
REQ-015 sum_valid SHALL be 1 only in DONE.
REQ-016 First element of a sum (count==0) in ACCEPT:
- acc <= in_data, with bit 31 inverted when in_sub=1; no adder is used.
- count <= 1.
- Next state is DONE if in_last=1, else ACCEPT.
REQ-017 Later element (count>0) in ACCEPT:
- Register op_a <= acc, op_b <= in_data, op_neg <= in_sub, last_q <= in_last.
- Next state is ISSUE.
REQ-018 ISSUE SHALL hold op_a, op_b and op_neg stable on the adder sub-module inputs for one edge, then move to CAPTURE.
REQ-019 CAPTURE SHALL load acc from the adder output and increment count, then move to DONE if last_q=1, else to ACCEPT.
REQ-020 Throughput SHALL be 1 element per cycle for the first element and 1 element per 3 cycles for later elements.
REQ-021 count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 In DONE, sum_data SHALL equal acc and sum_count SHALL equal count, both held stable until the handshake.
REQ-023 On the DONE handshake edge:
- acc <= 32'h00000000 and count <= 0.
- Next state is ACCEPT.
- No new element is accepted in that same cycle.
REQ-024 With sum_ready=0, DONE SHALL persist indefinitely.
REQ-025 in_data, in_sub and in_last SHALL be ignored whenever in_ready=0.
REQ-026 Adder output SHALL be sampled only in CAPTURE; its value in all other cycles is don't-care.
REQ-027 No NaN/Inf/denormal special-casing is done here; arithmetic semantics are those of the adder sub-module.

Reset
REQ-028 While reset_n=0 at a rising edge:
- state <= ACCEPT, acc <= 0, count <= 0, last_q <= 0, op_a/op_b/op_neg <= 0.
- sum_valid=0 and in_ready=0.
REQ-029 Reset asserted mid-sum (ISSUE, CAPTURE or DONE) SHALL discard the partial or completed sum with no sum_valid pulse.
REQ-030 in_ready SHALL become 1 in the first cycle after reset_n is sampled high.

Structure
REQ-031 Shared package float_pkg SHALL hold:
- the FSM state encoding (2 bits);
- FP_ZERO = 32'h00000000;
- FP_SIGN_BIT = 31.
REQ-032 Exactly one sub-module SHALL be instantiated: the existing single-cycle adder floating, with a=op_a, b=op_b, negate=op_neg, clk=clk, and debug left unconnected.

Verification
REQ-033 Add two elements:
- Stimulus: 3F800000 (not last), then 40000000 (last), sum_ready=1.
- Response: sum_data=40400000, sum_count=2; sum_valid rises 3 cycles after the second accept.
REQ-034 Single subtracted element:
- Stimulus: 3F800000, in_sub=1, in_last=1.
- Response: sum_valid the next cycle, sum_data=BF800000, sum_count=1, adder not exercised.
REQ-035 Subtract second element:
- Stimulus: 40400000, then 3F800000 with in_sub=1 and last.
- Response: sum_data=40000000, sum_count=2.
REQ-036 Backpressure:
- Stimulus: sum of 3F000000+3F000000 with sum_ready=0 for 5 cycles.
- Response: sum_data=3F800000 held stable, in_ready=0 throughout; handshake, then in_ready=1 the next cycle with count cleared.
REQ-037 Reset mid-sum:
- Stimulus: reset_n=0 in CAPTURE of a 2-element sum, then a new 1-element sum of 3FC00000.
- Response: no sum_valid for the aborted sum; new sum_data=3FC00000, sum_count=1.
REQ-038 Counter saturation:
- Stimulus: CNT_W=2, 5 elements of 3F800000 with the last flagged.
- Response: sum_count=3 (saturated), sum_data=40A00000.
